// File: rtl/violet_host.sv
// violet_host: host-side UART peer of the violet virtual I/O core.
// Sends A5/lo/hi button frames and parses A5/lo/hi LED frames.
module violet_host #(
  parameter int BAUD_DIV    = 2604,
  parameter int REFRESH_DIV = 2500000
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic [15:0] buttons,
  output logic [15:0] leds,
  output logic        leds_valid,
  output logic        frame_err,
  output logic        tx_busy,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int BW  = $clog2(BAUD_DIV + 1);
  localparam int RW  = $clog2(REFRESH_DIV + 1);
  localparam int GAP = 50 * BAUD_DIV;
  localparam int GW  = $clog2(GAP + 1);

  localparam logic [BW-1:0] BMAX  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BHALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [RW-1:0] RMAX  = RW'(REFRESH_DIV - 1);
  localparam logic [GW-1:0] GMAX  = GW'(GAP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] P_SYNC = 2'd0;
  localparam logic [1:0] P_LO   = 2'd1;
  localparam logic [1:0] P_HI   = 2'd2;

  logic [1:0]    tx_st;
  logic [BW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [1:0]    tx_byte;
  logic [23:0]   tx_sh;
  logic [15:0]   last_sent;
  logic [RW-1:0] ref_cnt;
  logic          tx_go;

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic [1:0]    rx_st;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_ok;
  logic          rx_bad;

  logic [1:0]    p_st;
  logic [7:0]    lo;
  logic [GW-1:0] gap_cnt;

  assign tx_go = !tx_busy &&
                 ((buttons != last_sent) || (ref_cnt == RMAX));

  // Refresh timer: cleared on every frame start, saturates otherwise
  always_ff @(posedge i_clk) begin
    if (rst)
      ref_cnt <= '0;
    else if (tx_go)
      ref_cnt <= '0;
    else if (ref_cnt != RMAX)
      ref_cnt <= ref_cnt + 1'b1;
  end

  // TX byte engine: three framed bytes back-to-back per button frame
  always_ff @(posedge i_clk) begin
    if (rst) begin
      tx_st     <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_byte   <= '0;
      tx_sh     <= '0;
      last_sent <= '0;
      tx_busy   <= 1'b0;
      uart_tx   <= 1'b1;
    end else begin
      case (tx_st)
        S_IDLE: begin
          if (tx_go) begin
            tx_st     <= S_START;
            tx_cnt    <= '0;
            tx_byte   <= '0;
            tx_sh     <= {buttons, 8'hA5};
            last_sent <= buttons;
            tx_busy   <= 1'b1;
            uart_tx   <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == BMAX) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_st   <= S_DATA;
            uart_tx <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == BMAX) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b0, tx_sh[23:1]};
            if (tx_bit == 3'd7) begin
              tx_st   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              uart_tx <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == BMAX) begin
            tx_cnt <= '0;
            if (tx_byte == 2'd2) begin
              tx_st   <= S_IDLE;
              tx_busy <= 1'b0;
            end else begin
              tx_byte <= tx_byte + 1'b1;
              tx_st   <= S_START;
              uart_tx <= 1'b0;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Two-flop synchroniser plus edge history for the serial input
  always_ff @(posedge i_clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX byte engine: mid-bit sampling, idle again right after stop sample
  always_ff @(posedge i_clk) begin
    if (rst) begin
      rx_st  <= S_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
      rx_ok  <= 1'b0;
      rx_bad <= 1'b0;
    end else begin
      rx_ok  <= 1'b0;
      rx_bad <= 1'b0;
      case (rx_st)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_st  <= S_START;
            rx_cnt <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == BHALF) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == BMAX) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7)
              rx_st <= S_STOP;
            else
              rx_bit <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BMAX) begin
            rx_cnt <= '0;
            rx_st  <= S_IDLE;
            rx_ok  <= rx_s2;
            rx_bad <= !rx_s2;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame parser with inter-byte timeout inside a frame
  always_ff @(posedge i_clk) begin
    if (rst) begin
      p_st       <= P_SYNC;
      lo         <= '0;
      gap_cnt    <= '0;
      leds       <= '0;
      leds_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      leds_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_bad) begin
        p_st      <= P_SYNC;
        gap_cnt   <= '0;
        frame_err <= 1'b1;
      end else if (rx_ok) begin
        gap_cnt <= '0;
        case (p_st)
          P_SYNC: if (rx_sh == 8'hA5) p_st <= P_LO;
          P_LO: begin
            lo   <= rx_sh;
            p_st <= P_HI;
          end
          default: begin
            leds       <= {rx_sh, lo};
            leds_valid <= 1'b1;
            p_st       <= P_SYNC;
          end
        endcase
      end else if (p_st != P_SYNC) begin
        if (gap_cnt == GMAX) begin
          p_st      <= P_SYNC;
          gap_cnt   <= '0;
          frame_err <= 1'b1;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_violet_host.sv
// tb_violet_host: directed bench for violet_host.
// Decodes uart_tx frames, drives uart_rx frames, optional loopback.
module tb_violet_host;

  localparam int B = 8;
  localparam int R = 2000;
  localparam int LIMIT = 40 * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] buttons = 16'h0000;
  logic [15:0] leds;
  logic        leds_valid;
  logic        frame_err;
  logic        tx_busy;
  logic        tx;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;
  logic        rx_line;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;

  assign rx_line = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  violet_host #(.BAUD_DIV(B), .REFRESH_DIV(R)) dut (
    .i_clk(clk),
    .rst(rst),
    .buttons(buttons),
    .leds(leds),
    .leds_valid(leds_valid),
    .frame_err(frame_err),
    .tx_busy(tx_busy),
    .uart_rx(rx_line),
    .uart_tx(tx)
  );

  always @(negedge clk) begin
    if (leds_valid === 1'b1) vcnt++;
    if (frame_err === 1'b1) ecnt++;
  end

  task automatic get_byte(output logic [7:0] b, output bit ok);
    int t;
    ok = 0;
    b = 8'h00;
    t = 0;
    while (tx !== 1'b0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) return;
    repeat (B / 2) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int k = 0; k < 8; k++) begin
      repeat (B) @(negedge clk);
      b[k] = tx;
    end
    repeat (B) @(negedge clk);
    if (tx !== 1'b1) return;
    ok = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    repeat (B) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_drv = b[k];
      repeat (B) @(negedge clk);
    end
    rx_drv = stop;
    repeat (B) @(negedge clk);
    if (!stop) begin
      rx_drv = 1'b1;
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] exp_b [3];
    logic [7:0] b;
    bit ok;
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    for (int i = 0; i < 3; i++) begin
      get_byte(b, ok);
      checks++;
      if (!ok || b !== exp_b[i]) begin
        errors++;
        $display("FAIL %s byte%0d: got %h ok=%0d, want %h",
                 name, i, b, ok, exp_b[i]);
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (tx_busy !== 1'b0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: tx_busy=%b, want 0", tx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (leds !== 16'h0000) begin
      errors++; $display("FAIL rst_leds: got %h want 0000", leds);
    end
    if (leds_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b want 0", leds_valid);
    end
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL rst_err: got %b want 0", frame_err);
    end
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", tx_busy);
    end
    if (tx !== 1'b1) begin
      errors++; $display("FAIL rst_tx: got %b want 1", tx);
    end
    rst = 1'b0;
  endtask

  task automatic test_refresh();
    int n;
    n = 0;
    while (tx_busy !== 1'b1 && n < 2 * R) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != R) begin
      errors++;
      $display("FAIL refresh_delay: got %0d cycles want %0d", n, R);
    end
    expect_frame("refresh", 8'hA5, 8'h00, 8'h00);
  endtask

  task automatic test_button_frame();
    int n;
    int low;
    int t;
    bit first;
    n = 0;
    low = 0;
    t = 0;
    first = 1;
    wait_idle();
    buttons = 16'h4001;
    fork
      expect_frame("btn4001", 8'hA5, 8'h01, 8'h40);
      begin
        while (tx_busy !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        while (tx_busy === 1'b1 && n < LIMIT) begin
          if (first) begin
            if (tx === 1'b0) low++;
            else first = 0;
          end
          n++;
          @(negedge clk);
        end
      end
    join
    checks += 2;
    if (n != 30 * B) begin
      errors++;
      $display("FAIL busy_len: got %0d want %0d", n, 30 * B);
    end
    if (low != B) begin
      errors++;
      $display("FAIL bit_time: got %0d want %0d", low, B);
    end
  endtask

  task automatic test_change_mid_frame();
    logic [7:0] b;
    bit ok;
    wait_idle();
    buttons = 16'h00FF;
    get_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hA5) begin
      errors++;
      $display("FAIL mid_sync: got %h ok=%0d want a5", b, ok);
    end
    buttons = 16'h1234;
    get_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hFF) begin
      errors++;
      $display("FAIL mid_lo: got %h ok=%0d want ff", b, ok);
    end
    get_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h00) begin
      errors++;
      $display("FAIL mid_hi: got %h ok=%0d want 00", b, ok);
    end
    expect_frame("next1234", 8'hA5, 8'h34, 8'h12);
  endtask

  task automatic test_rx_frames();
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (2 * B) @(negedge clk);
    checks += 3;
    if (leds !== 16'h1234) begin
      errors++; $display("FAIL rx_1234: got %h want 1234", leds);
    end
    if (vcnt - v0 != 1) begin
      errors++; $display("FAIL rx_valid1: got %0d want 1", vcnt - v0);
    end
    if (ecnt - e0 != 0) begin
      errors++; $display("FAIL rx_err1: got %0d want 0", ecnt - e0);
    end
    v0 = vcnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hAB, 1'b1);
    repeat (2 * B) @(negedge clk);
    checks += 2;
    if (leds !== 16'hABCD) begin
      errors++; $display("FAIL rx_abcd: got %h want abcd", leds);
    end
    if (vcnt - v0 != 1) begin
      errors++; $display("FAIL rx_valid2: got %0d want 1", vcnt - v0);
    end
  endtask

  task automatic test_bad_stop();
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (2 * B) @(negedge clk);
    checks += 3;
    if (ecnt - e0 != 1) begin
      errors++; $display("FAIL stop_err: got %0d want 1", ecnt - e0);
    end
    if (leds !== 16'h2211) begin
      errors++; $display("FAIL stop_leds: got %h want 2211", leds);
    end
    if (vcnt - v0 != 1) begin
      errors++; $display("FAIL stop_valid: got %0d want 1", vcnt - v0);
    end
  endtask

  task automatic test_gap_timeout();
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    send_byte(8'hA5, 1'b1);
    repeat (60 * B) @(negedge clk);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (2 * B) @(negedge clk);
    checks += 3;
    if (ecnt - e0 != 1) begin
      errors++; $display("FAIL gap_err: got %0d want 1", ecnt - e0);
    end
    if (vcnt - v0 != 0) begin
      errors++; $display("FAIL gap_valid: got %0d want 0", vcnt - v0);
    end
    if (leds !== 16'h2211) begin
      errors++; $display("FAIL gap_leds: got %h want 2211", leds);
    end
  endtask

  task automatic test_loopback();
    int v0;
    wait_idle();
    loop = 1'b1;
    repeat (2) @(negedge clk);
    v0 = vcnt;
    buttons = 16'h8001;
    repeat (40 * B) @(negedge clk);
    checks += 2;
    if (leds !== 16'h8001) begin
      errors++; $display("FAIL loop_leds: got %h want 8001", leds);
    end
    if (vcnt - v0 != 1) begin
      errors++; $display("FAIL loop_valid: got %0d want 1", vcnt - v0);
    end
    wait_idle();
    loop = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    buttons = 16'h5555;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h77, 1'b1);
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b want 1", tx_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL abort_tx: got %b want 1", tx);
    end
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy: got %b want 0", tx_busy);
    end
    if (leds !== 16'h0000) begin
      errors++; $display("FAIL abort_leds: got %h want 0000", leds);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    v0 = vcnt;
    send_byte(8'h99, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (2 * B) @(negedge clk);
    checks += 2;
    if (leds !== 16'h0201) begin
      errors++; $display("FAIL after_leds: got %h want 0201", leds);
    end
    if (vcnt - v0 != 1) begin
      errors++; $display("FAIL after_valid: got %0d want 1", vcnt - v0);
    end
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_button_frame();
    test_change_mid_frame();
    test_rx_frames();
    test_bad_stop();
    test_gap_timeout();
    test_loopback();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
